y_change_writer: RTL and testbench
==================================

# y_change_writer

Write-side counterpart of the Y address decoder. Accepts one change entry per handshake (row, col, 16-bit value). Resolves the row's base line through the Y index table, then performs a read-modify-write of the target 256-bit Y line. Sits between the change-file parser and the Y line memory; shares that memory's single address/read/write port with the decoder under top-level arbitration.

## Interface
- ADDR_W, 11, Y memory line address width
- LINE_W, 256, Y memory line width
- WORD_W, 16, entry width; LINE_W/WORD_W = 16 words per line
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- yW_inValid  input  1  change entry valid
- yW_inReady  output  1  block can accept an entry
- yW_row  input  16  Y row; 16'hFFFF = end-of-stream marker
- yW_col  input  16  Y column
- yW_value  input  16  new entry value
- yW_memAddr  output  11  memory line address
- yW_memReadEn  output  1  read strobe; data returned next cycle
- yW_memReadData  input  256  read data, valid the cycle after yW_memReadEn
- yW_memWriteEn  output  1  write strobe, single cycle
- yW_memWriteData  output  256  write data
- yW_busy  output  1  high in every state except IDLE
- yW_done  output  1  one-cycle pulse after end-of-stream accepted

## Operation
- States: IDLE, IDX, IDXW, DAT, DATW, WR, DONE.
- Accept: yW_inValid && yW_inReady. yW_inReady = 1 only in IDLE. Entry is latched on accept.
- IDLE -> DONE if latched row == 16'hFFFF. Otherwise IDLE -> IDX.
- IDX: yW_memAddr = row[14:4], yW_memReadEn = 1. row[15] is ignored for non-marker rows.
- IDXW: capture base = word row[3:0] of yW_memReadData. Word k occupies bits [16k+15:16k]. Take base[10:0].
- DAT: yW_memAddr = base[10:0] + col[14:4]. The sum is 11 bits and wraps modulo 2048. yW_memReadEn = 1.
- DATW: capture line = yW_memReadData.
- WR: yW_memAddr = DAT address; yW_memWriteEn = 1.
  - yW_memWriteData = captured line with word col[3:0] replaced by yW_value.
  - All other 15 words are unchanged. Then -> IDLE.
- DONE: yW_done = 1 for one cycle, then -> IDLE.
- Read and write strobes are never high in the same cycle. Strobes are high only in the states listed above.
- yW_memAddr = 11'h7FF when no strobe is active.

## Timing
- All outputs are registered or decoded from the state register.
- Reset values: yW_inReady 0, yW_busy 0, yW_done 0, yW_memReadEn 0, yW_memWriteEn 0, yW_memAddr 11'h7FF, yW_memWriteData 0. State = IDLE.
- yW_inReady rises the first cycle after reset deasserts.
- Cycle timeline (cycle 0 = accept): cycle 1 IDX read, cycle 2 IDXW capture, cycle 3 DAT read, cycle 4 DATW capture, cycle 5 WR, cycle 6 IDLE with yW_inReady = 1.
- Throughput: one change per 6 cycles.
- End-of-stream: accept at cycle 0, yW_done in cycle 1, yW_inReady again in cycle 2.
- Back-to-back entries to the same line need no forwarding: the write completes in cycle 5, before the next read at the earliest in cycle 7.
- yW_inValid is ignored outside IDLE; the entry is held by the source until accepted.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight entry is dropped.
  - If reset asserts in any state before WR, no write occurs.
  - A write already strobed in WR is complete.
- Column wrap: base 0x7F0 with col[14:4] = 0x020 gives address 0x010.

## Structure
- Package y_mem_pkg:
  - Y_ADDR_W = 11, Y_LINE_W = 256, Y_WORD_W = 16, Y_WORDS = 16
  - Y_END_ROW = 16'hFFFF, Y_IDLE_ADDR = 11'h7FF
  - state enum (IDLE..DONE)
- Sub-module y_line_merge: combinational. Inputs: line[255:0], sel[3:0], value[15:0]. Output: line with word sel replaced. Reusable by other Y writers.

## Test plan
- Reset: hold reset low for 3 cycles -> all outputs at reset values; yW_inReady = 1 in the first cycle after release.
- Basic RMW: row 0x0023, col 0x0015, value 0xBEEF.
  - Index line 2, word 3 = 0x0100 -> read 0x002 (cycle 1), read 0x101 (cycle 3).
  - Cycle 5: write 0x101, word 5 = 0xBEEF, other 15 words match the preloaded line.
- Address wrap: index word = 0x07F0, col 0x0200 -> data read and write at 0x010.
- End-of-stream: row 0xFFFF -> yW_done pulses in cycle 1, no memory strobes, yW_inReady high in cycle 2.
- Back-to-back same line: two entries to the same line, different words -> second write contains both new values; accepts spaced 6 cycles apart.
- Reset mid-operation: assert reset in DATW -> yW_memWriteEn never rises, memory is unchanged, FSM resumes from IDLE.

Source files
------------

// File: rtl/y_mem_pkg.sv
// Shared Y line memory constants, FSM state type and word-extract helper.
package y_mem_pkg;

  localparam int Y_ADDR_W = 11;
  localparam int Y_LINE_W = 256;
  localparam int Y_WORD_W = 16;
  localparam int Y_WORDS  = Y_LINE_W / Y_WORD_W;

  localparam logic [15:0]         Y_END_ROW   = 16'hFFFF;
  localparam logic [Y_ADDR_W-1:0] Y_IDLE_ADDR = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    IDX,
    IDXW,
    DAT,
    DATW,
    WR,
    DONE
  } yw_state_t;

  // Word k of a line occupies bits [16k+15:16k].
  function automatic logic [Y_WORD_W-1:0] yWord(input logic [Y_LINE_W-1:0] line,
                                               input logic [3:0] sel);
    return line[{sel, 4'b0000} +: Y_WORD_W];
  endfunction

endpackage

// File: rtl/y_change_writer_if.sv
// Change-entry handshake plus the Y memory port, bundled for the writer.
interface y_change_writer_if;
  import y_mem_pkg::*;

  logic                yW_inValid;
  logic                yW_inReady;
  logic [15:0]         yW_row;
  logic [15:0]         yW_col;
  logic [Y_WORD_W-1:0] yW_value;
  logic [Y_ADDR_W-1:0] yW_memAddr;
  logic                yW_memReadEn;
  logic [Y_LINE_W-1:0] yW_memReadData;
  logic                yW_memWriteEn;
  logic [Y_LINE_W-1:0] yW_memWriteData;
  logic                yW_busy;
  logic                yW_done;

  // Environment side: parser feeding entries and the memory returning data.
  modport master (
    output yW_inValid, yW_row, yW_col, yW_value, yW_memReadData,
    input  yW_inReady, yW_memAddr, yW_memReadEn, yW_memWriteEn,
           yW_memWriteData, yW_busy, yW_done
  );

  // Writer side.
  modport slave (
    input  yW_inValid, yW_row, yW_col, yW_value, yW_memReadData,
    output yW_inReady, yW_memAddr, yW_memReadEn, yW_memWriteEn,
           yW_memWriteData, yW_busy, yW_done
  );

endinterface

// File: rtl/y_line_merge.sv
// Replaces one 16-bit word of a 256-bit Y line; all other words pass through.
module y_line_merge
  import y_mem_pkg::*;
(
  input  logic [Y_LINE_W-1:0] line,
  input  logic [3:0]          sel,
  input  logic [Y_WORD_W-1:0] value,
  output logic [Y_LINE_W-1:0] merged
);

  // Copy the line, then overwrite the selected word.
  always_comb begin
    merged = line;
    merged[{sel, 4'b0000} +: Y_WORD_W] = value;
  end

endmodule

// File: rtl/y_change_writer.sv
// Y change writer: index lookup followed by read-modify-write of one Y line.
//
// state | meaning
// IDLE  | ready for an entry
// IDX   | index line read strobe (row[14:4])
// IDXW  | index data back; base captured, data address formed
// DAT   | data line read strobe (base + col[14:4])
// DATW  | data line back; merged line captured
// WR    | write strobe of the merged line
// DONE  | end-of-stream pulse
module y_change_writer
  import y_mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  y_change_writer_if.slave yW
);

  yw_state_t           state;
  logic                inReadyR, busyR, doneR, readEnR, writeEnR;
  logic [Y_ADDR_W-1:0] addrR;
  logic [Y_LINE_W-1:0] writeDataR;

  logic [3:0]          rowWord;
  logic [3:0]          colWord;
  logic [Y_ADDR_W-1:0] colLine;
  logic [Y_WORD_W-1:0] valueReg;
  logic [Y_ADDR_W-1:0] dataAddr;
  logic [Y_ADDR_W-1:0] dataAddrNext;
  logic [Y_LINE_W-1:0] mergedLine;

  // Base is the low 11 bits of the index word; the add wraps modulo 2048.
  assign dataAddrNext = Y_ADDR_W'(yWord(yW.yW_memReadData, rowWord)) + colLine;

  y_line_merge uMerge (
    .line   (yW.yW_memReadData),
    .sel    (colWord),
    .value  (valueReg),
    .merged (mergedLine)
  );

  // Sequencer with registered handshake and memory-port outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      inReadyR   <= 1'b0;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      readEnR    <= 1'b0;
      writeEnR   <= 1'b0;
      addrR      <= Y_IDLE_ADDR;
      writeDataR <= '0;
      rowWord    <= '0;
      colWord    <= '0;
      colLine    <= '0;
      valueReg   <= '0;
      dataAddr   <= '0;
    end else begin
      readEnR  <= 1'b0;
      writeEnR <= 1'b0;
      doneR    <= 1'b0;
      addrR    <= Y_IDLE_ADDR;
      case (state)
        IDLE: begin
          inReadyR <= 1'b1;
          busyR    <= 1'b0;
          if (yW.yW_inValid && inReadyR) begin
            rowWord  <= yW.yW_row[3:0];
            colWord  <= yW.yW_col[3:0];
            colLine  <= yW.yW_col[14:4];
            valueReg <= yW.yW_value;
            inReadyR <= 1'b0;
            busyR    <= 1'b1;
            if (yW.yW_row == Y_END_ROW) begin
              state <= DONE;
              doneR <= 1'b1;
            end else begin
              state   <= IDX;
              readEnR <= 1'b1;
              addrR   <= yW.yW_row[14:4];
            end
          end
        end
        IDX: state <= IDXW;
        IDXW: begin
          dataAddr <= dataAddrNext;
          addrR    <= dataAddrNext;
          readEnR  <= 1'b1;
          state    <= DAT;
        end
        DAT: state <= DATW;
        DATW: begin
          writeDataR <= mergedLine;
          writeEnR   <= 1'b1;
          addrR      <= dataAddr;
          state      <= WR;
        end
        WR, DONE: begin
          state    <= IDLE;
          inReadyR <= 1'b1;
          busyR    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign yW.yW_inReady      = inReadyR;
  assign yW.yW_busy         = busyR;
  assign yW.yW_done         = doneR;
  assign yW.yW_memReadEn    = readEnR;
  assign yW.yW_memWriteEn   = writeEnR;
  assign yW.yW_memAddr      = addrR;
  assign yW.yW_memWriteData = writeDataR;

endmodule

// File: tb/tb_y_change_writer.sv
// Bench for y_change_writer: Y memory model, line-level reference model,
// directed vectors and randomized entries.
module tb_y_change_writer;
  import y_mem_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  y_change_writer_if yIf ();

  y_change_writer dut (
    .clock (clock),
    .reset (reset),
    .yW    (yIf)
  );

  logic [255:0] mem    [2048];
  logic [255:0] refMem [2048];
  bit           known  [2048];

  logic         pokeEn   = 1'b0;
  logic [10:0]  pokeAddr = '0;
  logic [255:0] pokeData = '0;

  int cycleCnt = 0, writeCnt = 0, bothCnt = 0, badAddrCnt = 0;
  int checks = 0, failures = 0;

  typedef struct {
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] value;
    logic [15:0] idxWord;
    logic [10:0] expAddr;
  } vec_t;

  // Y memory: one-cycle read latency, plus a bench-side preload port.
  always @(posedge clock) begin
    cycleCnt <= cycleCnt + 1;
    if (yIf.yW_memReadEn) yIf.yW_memReadData <= mem[yIf.yW_memAddr];
    if (yIf.yW_memWriteEn) begin
      mem[yIf.yW_memAddr] <= yIf.yW_memWriteData;
      writeCnt <= writeCnt + 1;
    end else if (pokeEn) begin
      mem[pokeAddr] <= pokeData;
    end
    if (yIf.yW_memReadEn && yIf.yW_memWriteEn) bothCnt <= bothCnt + 1;
    if (!yIf.yW_memReadEn && !yIf.yW_memWriteEn && yIf.yW_memAddr !== Y_IDLE_ADDR)
      badAddrCnt <= badAddrCnt + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] rnd256;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic poke(input logic [10:0] a, input logic [255:0] d);
    pokeAddr = a;
    pokeData = d;
    pokeEn   = 1'b1;
    tick;
    pokeEn    = 1'b0;
    refMem[a] = d;
    known[a]  = 1'b1;
  endtask

  // Reference: base = index word, address = (base + col/16) mod 2048.
  function automatic logic [10:0] modelAddr(input logic [15:0] row, input logic [15:0] col);
    logic [15:0] base;
    base = refMem[row[14:4]][row[3:0]*16 +: 16];
    return 11'((int'(base[10:0]) + int'(col[14:4])) % 2048);
  endfunction

  task automatic waitAccept(input logic [15:0] row, input logic [15:0] col,
                            input logic [15:0] value, output int acc);
    int n;
    yIf.yW_row     = row;
    yIf.yW_col     = col;
    yIf.yW_value   = value;
    yIf.yW_inValid = 1'b1;
    n = 0;
    while (yIf.yW_inReady !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("accept_ready", yIf.yW_inReady, 1'b1);
    acc = cycleCnt;
    tick;
    yIf.yW_inValid = 1'b0;
  endtask

  task automatic runEntry(input logic [15:0] row, input logic [15:0] col,
                          input logic [15:0] value, output int acc, output logic [10:0] obsAddr);
    logic [10:0]  iAddr, expA;
    logic [255:0] expLine;
    iAddr   = row[14:4];
    expA    = modelAddr(row, col);
    expLine = refMem[expA];
    expLine[col[3:0]*16 +: 16] = value;
    waitAccept(row, col, value, acc);
    chk("c1_readEn", yIf.yW_memReadEn, 1'b1);
    chk("c1_writeEn", yIf.yW_memWriteEn, 1'b0);
    chk("c1_addr", yIf.yW_memAddr, iAddr);
    chk("c1_busy", yIf.yW_busy, 1'b1);
    chk("c1_inReady", yIf.yW_inReady, 1'b0);
    tick;
    chk("c2_readEn", yIf.yW_memReadEn, 1'b0);
    chk("c2_addr", yIf.yW_memAddr, Y_IDLE_ADDR);
    tick;
    chk("c3_readEn", yIf.yW_memReadEn, 1'b1);
    chk("c3_addr", yIf.yW_memAddr, expA);
    tick;
    chk("c4_strobes", {yIf.yW_memReadEn, yIf.yW_memWriteEn}, 2'b00);
    tick;
    chk("c5_writeEn", yIf.yW_memWriteEn, 1'b1);
    chk("c5_readEn", yIf.yW_memReadEn, 1'b0);
    chk("c5_addr", yIf.yW_memAddr, expA);
    chk("c5_data", yIf.yW_memWriteData, expLine);
    obsAddr = yIf.yW_memAddr;
    tick;
    chk("c6_inReady", yIf.yW_inReady, 1'b1);
    chk("c6_busy", yIf.yW_busy, 1'b0);
    chk("c6_writeEn", yIf.yW_memWriteEn, 1'b0);
    chk("c6_mem", mem[expA], expLine);
    refMem[expA] = expLine;
    known[expA]  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[4];
    int           acc1, acc2, wc;
    logic [10:0]  obs, iAddr, dA;
    logic [255:0] line;
    logic [15:0]  row, col;

    yIf.yW_inValid = 1'b0;
    yIf.yW_row     = '0;
    yIf.yW_col     = '0;
    yIf.yW_value   = '0;

    // Reset held low for 3 cycles.
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_inReady", yIf.yW_inReady, 1'b0);
    chk("rst_busy", yIf.yW_busy, 1'b0);
    chk("rst_done", yIf.yW_done, 1'b0);
    chk("rst_readEn", yIf.yW_memReadEn, 1'b0);
    chk("rst_writeEn", yIf.yW_memWriteEn, 1'b0);
    chk("rst_addr", yIf.yW_memAddr, Y_IDLE_ADDR);
    chk("rst_wdata", yIf.yW_memWriteData, 256'h0);
    reset = 1'b1;
    tick;
    chk("rel_inReady", yIf.yW_inReady, 1'b1);
    chk("rel_busy", yIf.yW_busy, 1'b0);

    // Directed vectors: basic RMW, column wrap, row[15] ignored with wrap, zero.
    vecs[0] = '{row: 16'h0023, col: 16'h0015, value: 16'hBEEF, idxWord: 16'h0100, expAddr: 11'h101};
    vecs[1] = '{row: 16'h0040, col: 16'h0200, value: 16'h1234, idxWord: 16'h07F0, expAddr: 11'h010};
    vecs[2] = '{row: 16'h8011, col: 16'h7FFF, value: 16'hA5A5, idxWord: 16'hF805, expAddr: 11'h004};
    vecs[3] = '{row: 16'h0000, col: 16'h0000, value: 16'h0001, idxWord: 16'h0000, expAddr: 11'h000};
    for (int i = 0; i < 4; i++) begin
      iAddr = vecs[i].row[14:4];
      poke(vecs[i].expAddr, rnd256());
      line = (iAddr == vecs[i].expAddr) ? refMem[iAddr] : rnd256();
      line[vecs[i].row[3:0]*16 +: 16] = vecs[i].idxWord;
      poke(iAddr, line);
      runEntry(vecs[i].row, vecs[i].col, vecs[i].value, acc1, obs);
      chk($sformatf("vec%0d_addr", i), obs, vecs[i].expAddr);
    end
    chk("basic_word5", mem[11'h101][5*16 +: 16], 16'hBEEF);

    // End-of-stream marker.
    wc = writeCnt;
    waitAccept(16'hFFFF, 16'h0000, 16'h0000, acc1);
    chk("eos_c1_done", yIf.yW_done, 1'b1);
    chk("eos_c1_strobes", {yIf.yW_memReadEn, yIf.yW_memWriteEn}, 2'b00);
    chk("eos_c1_addr", yIf.yW_memAddr, Y_IDLE_ADDR);
    chk("eos_c1_inReady", yIf.yW_inReady, 1'b0);
    tick;
    chk("eos_c2_done", yIf.yW_done, 1'b0);
    chk("eos_c2_inReady", yIf.yW_inReady, 1'b1);
    chk("eos_c2_busy", yIf.yW_busy, 1'b0);
    chk("eos_nowrite", writeCnt, wc);

    // Back-to-back entries to the same data line.
    line = rnd256();
    line[0 +: 16] = 16'h0030;
    poke(11'h005, line);
    poke(11'h031, rnd256());
    runEntry(16'h0050, 16'h0012, 16'h1111, acc1, obs);
    runEntry(16'h0050, 16'h0017, 16'h2222, acc2, obs);
    chk("b2b_spacing", acc2 - acc1, 6);
    chk("b2b_word2", mem[11'h031][2*16 +: 16], 16'h1111);
    chk("b2b_word7", mem[11'h031][7*16 +: 16], 16'h2222);

    // Reset asserted during DATW drops the entry.
    line = rnd256();
    line[1*16 +: 16] = 16'h0100;
    poke(11'h006, line);
    poke(11'h104, rnd256());
    waitAccept(16'h0061, 16'h0043, 16'hCAFE, acc1);
    tick;
    tick;
    tick;
    wc = writeCnt;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", yIf.yW_busy, 1'b0);
    chk("mid_rst_strobes", {yIf.yW_memReadEn, yIf.yW_memWriteEn}, 2'b00);
    chk("mid_rst_addr", yIf.yW_memAddr, Y_IDLE_ADDR);
    repeat (3) tick;
    chk("mid_rst_nowrite", writeCnt, wc);
    chk("mid_rst_mem", mem[11'h104], refMem[11'h104]);
    reset = 1'b1;
    tick;
    chk("mid_rst_inReady", yIf.yW_inReady, 1'b1);
    runEntry(16'h0061, 16'h0043, 16'hCAFE, acc1, obs);
    chk("mid_rst_resume_addr", obs, 11'h104);

    // Randomized entries against the line-level model.
    for (int i = 0; i < 30; i++) begin
      row = 16'($urandom);
      row[14:4] = 11'($urandom_range(0, 7));
      col = 16'($urandom);
      iAddr = row[14:4];
      if (!known[iAddr]) poke(iAddr, rnd256());
      dA = modelAddr(row, col);
      if (!known[dA]) poke(dA, rnd256());
      runEntry(row, col, 16'($urandom), acc1, obs);
    end

    chk("never_both_strobes", bothCnt, 0);
    chk("idle_addr_7ff", badAddrCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
